// File: rtl/pixel_trigger_gen_if.sv
// Read bus between the trigger generator and the
// timestamp/active-pixel memory group.
interface pixel_trigger_gen_if #(
  parameter int ADDR_W = 11,
  parameter int TS_W   = 16
);
  logic [ADDR_W-1:0] raddr_o;
  logic [TS_W-1:0]   timestamp_i;
  logic              active_pixel_i;

  modport master (
    output raddr_o,
    input  timestamp_i,
    input  active_pixel_i
  );

  modport slave (
    input  raddr_o,
    output timestamp_i,
    output active_pixel_i
  );
endinterface

// File: rtl/pixel_trigger_gen.sv
// Walks one scan line of the timestamp memory and
// pulses a trigger per active pixel on its tick count.
module pixel_trigger_gen #(
  parameter int ADDR_W = 11,
  parameter int TS_W   = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              enable_i,
  input  logic              line_sync_i,
  input  logic [ADDR_W-1:0] pixels_per_line_i,
  input  logic              clear_overrun_i,
  pixel_trigger_gen_if.master mem,
  output logic              pixel_trig_o,
  output logic              new_line_o,
  output logic              busy_o,
  output logic              overrun_o
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    COUNT,
    DONE
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] raddr_q, raddr_d;
  logic [ADDR_W-1:0] ppl_q, ppl_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [TS_W-1:0]   cnt_q, cnt_d;
  logic [TS_W-1:0]   eff_ts;
  logic              act_q, act_d;
  logic              trig_q, trig_d;
  logic              nl_q, nl_d;
  logic              ovr_q, ovr_d;
  logic              start_ok;
  logic              mid_line;
  logic              fire;
  logic              last_px;

  // Minimum of 2 ticks keeps the next entry's read data valid at reload.
  assign eff_ts = (mem.timestamp_i < TS_W'(2)) ?
                  TS_W'(2) : mem.timestamp_i;

  assign start_ok = line_sync_i &
                    (pixels_per_line_i != '0);
  assign mid_line = (state_q == FETCH) ||
                    (state_q == LOAD) ||
                    (state_q == COUNT);
  assign fire     = (state_q == COUNT) &&
                    (cnt_q == TS_W'(1));
  assign last_px  = (idx_q == ppl_q - ADDR_W'(1));

  // Next-state and datapath updates; abort paths take priority.
  always_comb begin
    state_d = state_q;
    raddr_d = raddr_q;
    ppl_d   = ppl_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    act_d   = act_q;
    trig_d  = 1'b0;
    nl_d    = 1'b0;
    ovr_d   = clear_overrun_i ? 1'b0 : ovr_q;
    if ((state_q != IDLE) && !enable_i) begin
      state_d = IDLE;
      raddr_d = '0;
      idx_d   = '0;
      cnt_d   = '0;
      act_d   = 1'b0;
    end else if (mid_line && line_sync_i) begin
      ovr_d   = 1'b1;
      raddr_d = '0;
      idx_d   = '0;
      cnt_d   = '0;
      act_d   = 1'b0;
      if (start_ok) begin
        ppl_d   = pixels_per_line_i;
        state_d = FETCH;
      end else begin
        state_d = IDLE;
      end
    end else begin
      unique case (state_q)
        IDLE: begin
          if (enable_i && start_ok) begin
            ppl_d   = pixels_per_line_i;
            raddr_d = '0;
            state_d = FETCH;
          end
        end
        FETCH: state_d = LOAD;
        LOAD: begin
          cnt_d   = eff_ts;
          act_d   = mem.active_pixel_i;
          idx_d   = '0;
          raddr_d = ADDR_W'(1);
          state_d = COUNT;
        end
        COUNT: begin
          if (fire) begin
            trig_d = act_q;
            if (last_px) begin
              nl_d    = 1'b1;
              state_d = DONE;
            end else begin
              cnt_d   = eff_ts;
              act_d   = mem.active_pixel_i;
              idx_d   = idx_q + ADDR_W'(1);
              raddr_d = raddr_q + ADDR_W'(1);
            end
          end else begin
            cnt_d = cnt_q - TS_W'(1);
          end
        end
        DONE: begin
          raddr_d = '0;
          idx_d   = '0;
          cnt_d   = '0;
          if (start_ok) begin
            ppl_d   = pixels_per_line_i;
            state_d = FETCH;
          end else begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      raddr_q <= '0;
      ppl_q   <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      act_q   <= 1'b0;
      trig_q  <= 1'b0;
      nl_q    <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      raddr_q <= raddr_d;
      ppl_q   <= ppl_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      act_q   <= act_d;
      trig_q  <= trig_d;
      nl_q    <= nl_d;
      ovr_q   <= ovr_d;
    end
  end

  assign mem.raddr_o  = raddr_q;
  assign pixel_trig_o = trig_q;
  assign new_line_o   = nl_q;
  assign busy_o       = (state_q != IDLE);
  assign overrun_o    = ovr_q;

endmodule

// File: tb/tb_pixel_trigger_gen.sv
// Bench for pixel_trigger_gen: line-schedule model,
// per-cycle compare, directed literal line checks.
module tb_pixel_trigger_gen;
  localparam int ADDR_W = 11;
  localparam int TS_W   = 16;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic              enable_i;
  logic              line_sync_i;
  logic [ADDR_W-1:0] pixels_per_line_i;
  logic              clear_overrun_i;
  logic              pixel_trig_o;
  logic              new_line_o;
  logic              busy_o;
  logic              overrun_o;

  pixel_trigger_gen_if #(
    .ADDR_W(ADDR_W),
    .TS_W(TS_W)
  ) mem_if ();

  pixel_trigger_gen #(
    .ADDR_W(ADDR_W),
    .TS_W(TS_W)
  ) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .enable_i(enable_i),
    .line_sync_i(line_sync_i),
    .pixels_per_line_i(pixels_per_line_i),
    .clear_overrun_i(clear_overrun_i),
    .mem(mem_if),
    .pixel_trig_o(pixel_trig_o),
    .new_line_o(new_line_o),
    .busy_o(busy_o),
    .overrun_o(overrun_o)
  );

  always #5 clk_i = ~clk_i;

  logic [TS_W-1:0] mem_ts  [2**ADDR_W];
  logic            mem_act [2**ADDR_W];

  // registered memory read, one cycle latency
  always @(posedge clk_i) begin
    mem_if.timestamp_i    <= mem_ts[mem_if.raddr_o];
    mem_if.active_pixel_i <= mem_act[mem_if.raddr_o];
  end

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  task automatic chk(input string nm,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @%0d: got %0h expected %0h",
               nm, cyc, got, exp);
    end
  endtask

  // ---------------- line-schedule model ----------------
  bit line_on = 1'b0;
  int s_m;
  int ppl_m;
  int tf[$];
  bit af[$];
  bit ov_m = 1'b0;

  function automatic int eff(input int dt);
    return (dt < 2) ? 2 : dt;
  endfunction

  task automatic start_line(input int s, input int n);
    int t;
    tf.delete();
    af.delete();
    t = s + 3;
    for (int k = 0; k < n; k++) begin
      t += eff(int'(mem_ts[k]));
      tf.push_back(t);
      af.push_back(mem_act[k]);
    end
    line_on = 1'b1;
    s_m     = s;
    ppl_m   = n;
  endtask

  task automatic exp_at(input int c,
                        output logic [63:0] ra,
                        output logic [63:0] tr,
                        output logic [63:0] nl,
                        output logic [63:0] bz);
    int n;
    ra = '0; tr = '0; nl = '0; bz = '0;
    if (line_on) begin
      bz = 1;
      n  = 0;
      if (c >= s_m + 3) begin
        n = 1;
        for (int k = 0; k < ppl_m - 1; k++)
          if (tf[k] <= c) n++;
      end
      ra = 64'(n);
      for (int k = 0; k < ppl_m; k++)
        if (tf[k] == c && af[k]) tr = 1;
      nl = (c == tf[ppl_m-1]) ? 64'd1 : 64'd0;
    end
  endtask

  task automatic model_step(input int c);
    bit set;
    int p;
    set = 1'b0;
    p   = int'(pixels_per_line_i);
    if (rst_i) begin
      line_on = 1'b0;
      ov_m    = 1'b0;
      return;
    end
    if (line_on) begin
      if (!enable_i) begin
        line_on = 1'b0;
      end else if (c == tf[ppl_m-1]) begin
        if (line_sync_i && p != 0) start_line(c, p);
        else line_on = 1'b0;
      end else if (line_sync_i) begin
        set = 1'b1;
        if (p != 0) start_line(c, p);
        else line_on = 1'b0;
      end
    end else if (line_sync_i && enable_i && p != 0) begin
      start_line(c, p);
    end
    if (set) ov_m = 1'b1;
    else if (clear_overrun_i) ov_m = 1'b0;
  endtask

  // per-cycle compare against the model, then advance it
  always @(negedge clk_i) begin
    logic [63:0] e_ra, e_tr, e_nl, e_bz;
    if (chk_en) begin
      exp_at(cyc, e_ra, e_tr, e_nl, e_bz);
      chk("raddr_o", 64'(mem_if.raddr_o), e_ra);
      chk("pixel_trig_o", 64'(pixel_trig_o), e_tr);
      chk("new_line_o", 64'(new_line_o), e_nl);
      chk("busy_o", 64'(busy_o), e_bz);
      chk("overrun_o", 64'(overrun_o), 64'(ov_m));
      model_step(cyc);
    end
  end

  // ---------------- recording for literal checks ----------------
  int rec_s = -1000000;
  logic [63:0]       r_trig, r_nl, r_busy, r_ovr;
  logic [ADDR_W-1:0] r_addr [64];

  always @(negedge clk_i) begin
    int r;
    r = cyc - rec_s;
    if (r >= 0 && r < 64) begin
      r_trig[r] = pixel_trig_o;
      r_nl[r]   = new_line_o;
      r_busy[r] = busy_o;
      r_ovr[r]  = overrun_o;
      r_addr[r] = mem_if.raddr_o;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic sync_go();
    r_trig = '0; r_nl = '0; r_busy = '0; r_ovr = '0;
    for (int i = 0; i < 64; i++) r_addr[i] = '0;
    rec_s = cyc;
    line_sync_i = 1'b1;
    tick(1);
    line_sync_i = 1'b0;
  endtask

  task automatic set_line(input int n,
                          input int d0, input int d1, input int d2,
                          input bit a0, input bit a1, input bit a2);
    mem_ts[0] = TS_W'(d0); mem_act[0] = a0;
    mem_ts[1] = TS_W'(d1); mem_act[1] = a1;
    mem_ts[2] = TS_W'(d2); mem_act[2] = a2;
    pixels_per_line_i = ADDR_W'(n);
  endtask

  initial begin
    logic [ADDR_W-1:0] addr_or;
    for (int i = 0; i < 2**ADDR_W; i++) begin
      mem_ts[i]  = '0;
      mem_act[i] = 1'b0;
    end
    rst_i = 1'b1;
    enable_i = 1'b0;
    line_sync_i = 1'b0;
    clear_overrun_i = 1'b0;
    pixels_per_line_i = '0;
    tick(3);
    chk_en = 1'b1;
    tick(1);
    rst_i = 1'b0;
    enable_i = 1'b1;
    tick(2);

    // basic line
    set_line(3, 5, 2, 4, 1, 1, 1);
    sync_go();
    tick(20);
    chk("l1 trig", r_trig, (64'd1 << 8) | (64'd1 << 10) | (64'd1 << 14));
    chk("l1 new_line", r_nl, 64'd1 << 14);
    chk("l1 busy", r_busy, 64'h7FFE);
    chk("l1 raddr@9", 64'(r_addr[9]), 64'd2);
    chk("l1 raddr@14", 64'(r_addr[14]), 64'd3);

    // clamped deltas
    set_line(2, 1, 0, 0, 1, 1, 0);
    sync_go();
    tick(15);
    chk("l2 trig", r_trig, (64'd1 << 5) | (64'd1 << 7));
    chk("l2 new_line", r_nl, 64'd1 << 7);

    // single pixel
    set_line(1, 3, 0, 0, 1, 0, 0);
    sync_go();
    tick(12);
    chk("l3 trig", r_trig, 64'd1 << 6);
    chk("l3 new_line", r_nl, 64'd1 << 6);
    chk("l3 raddr@6", 64'(r_addr[6]), 64'd1);

    // inactive middle pixel
    set_line(3, 5, 2, 4, 1, 0, 1);
    sync_go();
    tick(20);
    chk("l4 trig", r_trig, (64'd1 << 8) | (64'd1 << 14));
    chk("l4 new_line", r_nl, 64'd1 << 14);

    // overrun and restart
    set_line(3, 20, 2, 4, 1, 1, 1);
    sync_go();
    tick(9);
    line_sync_i = 1'b1;
    tick(1);
    line_sync_i = 1'b0;
    tick(19);
    clear_overrun_i = 1'b1;
    tick(1);
    clear_overrun_i = 1'b0;
    tick(20);
    chk("ov @10", 64'(r_ovr[10]), 64'd0);
    chk("ov @11", 64'(r_ovr[11]), 64'd1);
    chk("ov @30", 64'(r_ovr[30]), 64'd1);
    chk("ov @31", 64'(r_ovr[31]), 64'd0);
    chk("ov raddr@11", 64'(r_addr[11]), 64'd0);
    chk("ov new_line", r_nl, 64'd1 << 39);
    chk("ov trig", r_trig, (64'd1 << 33) | (64'd1 << 35) | (64'd1 << 39));

    // enable drop mid-line
    set_line(3, 5, 2, 4, 1, 1, 1);
    sync_go();
    tick(8);
    enable_i = 1'b0;
    tick(1);
    enable_i = 1'b1;
    tick(25);
    chk("en busy@9", 64'(r_busy[9]), 64'd1);
    chk("en busy@10", 64'(r_busy[10]), 64'd0);
    chk("en trig", r_trig, 64'd1 << 8);
    chk("en new_line", r_nl, 64'd0);

    // reset mid-line
    sync_go();
    tick(8);
    rst_i = 1'b1;
    tick(1);
    rst_i = 1'b0;
    tick(25);
    chk("rst busy@10", 64'(r_busy[10]), 64'd0);
    chk("rst trig", r_trig, 64'd1 << 8);
    chk("rst new_line", r_nl, 64'd0);

    // zero-length line is ignored
    set_line(0, 5, 2, 4, 1, 1, 1);
    sync_go();
    tick(20);
    addr_or = '0;
    for (int i = 0; i < 21; i++) addr_or |= r_addr[i];
    chk("ppl0 busy", r_busy, 64'd0);
    chk("ppl0 raddr", 64'(addr_or), 64'd0);
    chk("ppl0 trig", r_trig | r_nl, 64'd0);

    // randomized traffic against the model
    for (int rnd = 0; rnd < 6; rnd++) begin
      enable_i = 1'b0;
      line_sync_i = 1'b0;
      rst_i = 1'b0;
      tick(2);
      for (int k = 0; k < 8; k++) begin
        mem_ts[k]  = TS_W'($urandom_range(0, 6));
        mem_act[k] = 1'($urandom_range(0, 1));
      end
      for (int c = 0; c < 500; c++) begin
        enable_i = ($urandom_range(0, 31) != 0);
        line_sync_i = ($urandom_range(0, 9) == 0);
        pixels_per_line_i = ADDR_W'($urandom_range(0, 6));
        clear_overrun_i = ($urandom_range(0, 7) == 0);
        rst_i = ($urandom_range(0, 299) == 0);
        tick(1);
      end
    end

    rst_i = 1'b0;
    line_sync_i = 1'b0;
    enable_i = 1'b0;
    tick(3);
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
